// File: rtl/y_sig_pkg.sv
// Shared definitions for the y-bus signature compactor.
// Holds the FSM state encoding and the default MISR seed and polynomial.
package y_sig_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_RUN   = 2'd1;
  localparam state_t ST_CHECK = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

  localparam logic [31:0] Y_SIG_SEED = 32'hFFFF_FFFF;
  localparam logic [31:0] Y_SIG_POLY = 32'h04C1_1DB7;

endpackage

// File: rtl/y_fold.sv
// Combinational XOR fold of a wide result bus into one signature-width word.
// The bus is zero-padded to whole chunks; bit 0 of the bus lands in chunk 0 bit 0.
module y_fold #(
  parameter int Y_WIDTH   = 336,
  parameter int SIG_WIDTH = 32
) (
  input  logic [Y_WIDTH-1:0]   i_y,
  output logic [SIG_WIDTH-1:0] o_fold
);

  localparam int NCHUNK    = (Y_WIDTH + SIG_WIDTH - 1) / SIG_WIDTH;
  localparam int PAD_WIDTH = NCHUNK * SIG_WIDTH;

  logic [PAD_WIDTH-1:0] w_pad;

  assign w_pad = PAD_WIDTH'(i_y);

  always_comb begin
    o_fold = '0;
    for (int k = 0; k < NCHUNK; k++) begin
      o_fold = o_fold ^ w_pad[k*SIG_WIDTH +: SIG_WIDTH];
    end
  end

endmodule

// File: rtl/y_sig_compactor.sv
// MISR-based compactor: folds NUM_SAMPLES valid y samples into a signature,
// then compares the result against golden_sig once per run.
module y_sig_compactor
  import y_sig_pkg::*;
#(
  parameter int                   Y_WIDTH     = 336,
  parameter int                   SIG_WIDTH   = 32,
  parameter int                   NUM_SAMPLES = 20,
  parameter logic [SIG_WIDTH-1:0] SEED        = SIG_WIDTH'(Y_SIG_SEED),
  parameter logic [SIG_WIDTH-1:0] POLY        = SIG_WIDTH'(Y_SIG_POLY)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 y_valid,
  input  logic [Y_WIDTH-1:0]   y,
  input  logic [SIG_WIDTH-1:0] golden_sig,
  output logic                 busy,
  output logic                 done,
  output logic                 match,
  output logic [SIG_WIDTH-1:0] sig,
  output logic [15:0]          sample_cnt
);

  localparam logic [15:0] LAST_CNT = 16'(NUM_SAMPLES);

  state_t               r_state;
  logic [SIG_WIDTH-1:0] r_sig;
  logic [15:0]          r_cnt;
  logic                 r_match;
  logic [SIG_WIDTH-1:0] w_fold;
  logic [SIG_WIDTH-1:0] w_next_sig;

  y_fold #(
    .Y_WIDTH  (Y_WIDTH),
    .SIG_WIDTH(SIG_WIDTH)
  ) u_fold (
    .i_y   (y),
    .o_fold(w_fold)
  );

  assign w_next_sig = {r_sig[SIG_WIDTH-2:0], 1'b0}
                    ^ (r_sig[SIG_WIDTH-1] ? POLY : '0)
                    ^ w_fold;

  // Once the final sample lands, RUN spends one more cycle before CHECK,
  // giving a fixed two-cycle latency from the last sample to done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_sig   <= SEED;
      r_cnt   <= '0;
      r_match <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_state <= ST_RUN;
            r_sig   <= SEED;
            r_cnt   <= '0;
            r_match <= 1'b0;
          end
        end
        ST_RUN: begin
          if (abort) begin
            r_state <= ST_IDLE;
            r_match <= 1'b0;
          end else if (r_cnt == LAST_CNT) begin
            r_state <= ST_CHECK;
          end else if (y_valid) begin
            r_sig <= w_next_sig;
            r_cnt <= r_cnt + 16'd1;
          end
        end
        ST_CHECK: begin
          if (abort) begin
            r_state <= ST_IDLE;
            r_match <= 1'b0;
          end else begin
            r_match <= (r_sig == golden_sig);
            r_state <= ST_DONE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy       = (r_state == ST_RUN) || (r_state == ST_CHECK);
  assign done       = (r_state == ST_DONE);
  assign match      = r_match;
  assign sig        = r_sig;
  assign sample_cnt = r_cnt;

endmodule

// File: tb/tb_y_sig_compactor.sv
// Directed plus randomized checks of y_sig_compactor against a bit-level
// signature model; two instances cover the one-sample and twenty-sample cases.
module tb_y_sig_compactor;

  localparam int          YW   = 336;
  localparam logic [31:0] SEED = 32'hFFFF_FFFF;
  localparam logic [31:0] POLY = 32'h04C1_1DB7;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          abort;
  logic          y_valid;
  logic [YW-1:0] y;
  logic [31:0]   golden_sig;

  logic          d1_busy, d1_done, d1_match;
  logic [31:0]   d1_sig;
  logic [15:0]   d1_cnt;
  logic          d20_busy, d20_done, d20_match;
  logic [31:0]   d20_sig;
  logic [15:0]   d20_cnt;

  int compared   = 0;
  int mismatched = 0;

  y_sig_compactor #(.NUM_SAMPLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .y_valid(y_valid), .y(y), .golden_sig(golden_sig),
    .busy(d1_busy), .done(d1_done), .match(d1_match),
    .sig(d1_sig), .sample_cnt(d1_cnt)
  );

  y_sig_compactor #(.NUM_SAMPLES(20)) dut20 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .y_valid(y_valid), .y(y), .golden_sig(golden_sig),
    .busy(d20_busy), .done(d20_done), .match(d20_match),
    .sig(d20_sig), .sample_cnt(d20_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: each y bit is XORed into signature bit (index mod 32).
  function automatic logic [31:0] modelStep(input logic [31:0] s, input logic [YW-1:0] v);
    logic [31:0] f;
    f = '0;
    for (int i = 0; i < YW; i++) f[i % 32] = f[i % 32] ^ v[i];
    return (s << 1) ^ (s[31] ? POLY : 32'h0) ^ f;
  endfunction

  function automatic logic [YW-1:0] randY();
    logic [351:0] t;
    for (int i = 0; i < 11; i++) t[i*32 +: 32] = $urandom;
    return t[YW-1:0];
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic v, input logic [YW-1:0] yy, input logic a);
    start   = s;
    y_valid = v;
    y       = yy;
    abort   = a;
    @(negedge clk);
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    applyStimulus(0, 0, '0, 0);
    rst_n = 1'b1;
    applyStimulus(0, 0, '0, 0);
  endtask

  logic [31:0]   exp_sig;
  logic [YW-1:0] ones;
  int            acc;

  initial begin
    rst_n = 1'b0; start = 0; abort = 0; y_valid = 0; y = '0; golden_sig = '0;
    ones = '1;
    @(negedge clk);
    checkOutput("rst_sig",   d1_sig,          SEED);
    checkOutput("rst_cnt",   32'(d1_cnt),     32'd0);
    checkOutput("rst_busy",  32'(d1_busy),    32'd0);
    checkOutput("rst_done",  32'(d1_done),    32'd0);
    checkOutput("rst_match", 32'(d1_match),   32'd0);
    rst_n = 1'b1;
    applyStimulus(0, 0, '0, 0);

    $display("[TB] single zero sample, golden matches");
    golden_sig = 32'hFB3E_E249;
    applyStimulus(1, 0, '0, 0);
    checkOutput("z_busy_run", 32'(d1_busy), 32'd1);
    applyStimulus(0, 1, '0, 0);
    checkOutput("z_sig",      d1_sig,       32'hFB3E_E249);
    checkOutput("z_cnt",      32'(d1_cnt),  32'd1);
    checkOutput("z_done_e1",  32'(d1_done), 32'd0);
    applyStimulus(0, 1, randY(), 0);
    checkOutput("z_done_e2",  32'(d1_done), 32'd0);
    checkOutput("z_sig_held", d1_sig,       32'hFB3E_E249);
    applyStimulus(0, 0, '0, 0);
    checkOutput("z_done",     32'(d1_done),  32'd1);
    checkOutput("z_match",    32'(d1_match), 32'd1);
    checkOutput("z_busy",     32'(d1_busy),  32'd0);

    $display("[TB] single sample y=1, golden differs");
    applyStimulus(1, 0, '0, 0);
    checkOutput("o_match_clr", 32'(d1_match), 32'd0);
    applyStimulus(0, 1, YW'(1), 0);
    checkOutput("o_sig", d1_sig, 32'hFB3E_E248);
    applyStimulus(0, 0, '0, 0);
    applyStimulus(0, 0, '0, 0);
    checkOutput("o_done",  32'(d1_done),  32'd1);
    checkOutput("o_match", 32'(d1_match), 32'd0);

    $display("[TB] all-ones fold");
    y = ones;
    #1;
    checkOutput("fold_ones", dut1.u_fold.o_fold, 32'h0000_FFFF);
    applyStimulus(1, 0, ones, 0);
    applyStimulus(0, 1, ones, 0);
    checkOutput("ones_sig", d1_sig, modelStep(SEED, ones));

    $display("[TB] twenty samples with gapped valid and stray starts");
    doReset();
    applyStimulus(1, 0, '0, 0);
    exp_sig = SEED;
    acc = 0;
    for (int c = 0; c < 80 && acc < 20; c++) begin
      logic [YW-1:0] v;
      logic          val;
      v   = randY();
      val = (c % 2 == 0);
      applyStimulus((c == 5) || (c == 12), val, v, 0);
      if (val) begin
        exp_sig = modelStep(exp_sig, v);
        acc++;
      end
      checkOutput("r20_cnt",  32'(d20_cnt),  32'(acc));
      checkOutput("r20_sig",  d20_sig,       exp_sig);
      checkOutput("r20_done", 32'(d20_done), 32'd0);
    end
    checkOutput("r20_accepted", 32'(acc), 32'd20);
    golden_sig = exp_sig;
    applyStimulus(1, 1, randY(), 0);
    checkOutput("r20_check_done", 32'(d20_done), 32'd0);
    checkOutput("r20_check_busy", 32'(d20_busy), 32'd1);
    applyStimulus(0, 1, randY(), 0);
    checkOutput("r20_done_final", 32'(d20_done),  32'd1);
    checkOutput("r20_match",      32'(d20_match), 32'd1);
    checkOutput("r20_cnt_final",  32'(d20_cnt),   32'd20);
    checkOutput("r20_sig_final",  d20_sig,        exp_sig);
    applyStimulus(0, 1, randY(), 0);
    checkOutput("r20_done_hold",  32'(d20_done),  32'd1);
    checkOutput("r20_cnt_hold",   32'(d20_cnt),   32'd20);

    $display("[TB] reset mid-run then fresh run");
    applyStimulus(1, 0, '0, 0);
    for (int c = 0; c < 7; c++) applyStimulus(0, 1, randY(), 0);
    checkOutput("mr_cnt7", 32'(d20_cnt), 32'd7);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("mr_sig",  d20_sig,        SEED);
    checkOutput("mr_cnt",  32'(d20_cnt),   32'd0);
    checkOutput("mr_busy", 32'(d20_busy),  32'd0);
    checkOutput("mr_done", 32'(d20_done),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(0, 1, randY(), 0);
    checkOutput("mr_idle_cnt", 32'(d20_cnt), 32'd0);
    applyStimulus(1, 0, '0, 0);
    exp_sig = SEED;
    for (int c = 0; c < 20; c++) begin
      logic [YW-1:0] v;
      v = randY();
      applyStimulus(0, 1, v, 0);
      exp_sig = modelStep(exp_sig, v);
    end
    checkOutput("mr_new_sig", d20_sig, exp_sig);
    golden_sig = exp_sig ^ 32'h1;
    applyStimulus(0, 0, '0, 0);
    applyStimulus(0, 0, '0, 0);
    checkOutput("mr_new_done",  32'(d20_done),  32'd1);
    checkOutput("mr_new_match", 32'(d20_match), 32'd0);

    $display("[TB] abort with start and valid in RUN");
    applyStimulus(1, 0, '0, 0);
    exp_sig = SEED;
    for (int c = 0; c < 3; c++) begin
      logic [YW-1:0] v;
      v = randY();
      applyStimulus(0, 1, v, 0);
      exp_sig = modelStep(exp_sig, v);
    end
    applyStimulus(1, 1, randY(), 1);
    checkOutput("ab_busy",  32'(d20_busy),  32'd0);
    checkOutput("ab_done",  32'(d20_done),  32'd0);
    checkOutput("ab_sig",   d20_sig,        exp_sig);
    checkOutput("ab_cnt",   32'(d20_cnt),   32'd3);
    checkOutput("ab_match", 32'(d20_match), 32'd0);
    applyStimulus(0, 1, randY(), 0);
    checkOutput("ab_idle_sig", d20_sig,      exp_sig);
    checkOutput("ab_idle_cnt", 32'(d20_cnt), 32'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
